// File: rtl/game_grid_scan.sv
// 640x480@60 raster scanner: publishes the current tile coordinate to the game
// objects and composites their draw flags into registered RGB with aligned syncs.
module game_grid_scan #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int TILE_SHIFT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_draw_ball,
  input  logic       i_draw_p1,
  input  logic       i_draw_p2,
  output logic [5:0] o_col,
  output logic [5:0] o_row,
  output logic       o_frame_start,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [5:0] OFF_GRID   = 6'd63;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [2:0] blu;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{red: 3'd0, grn: 3'd0, blu: 3'd0};
  localparam rgb_t RGB_BALL  = '{red: 3'd7, grn: 3'd7, blu: 3'd7};
  localparam rgb_t RGB_P1    = '{red: 3'd0, grn: 3'd7, blu: 3'd0};
  localparam rgb_t RGB_P2    = '{red: 3'd0, grn: 3'd7, blu: 3'd7};

  logic [9:0] h_cnt, v_cnt;
  logic       h_wrap, v_wrap;
  logic       vis0, hs0_n, vs0_n;
  logic [5:0] col0, row0;
  logic       vis1, hs1_n, vs1_n;
  logic       vis2, hs2_n, vs2_n;
  rgb_t       pix_rgb, rgb_q;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // NOTE: non-blocking assignments in clocked blocks, so every register samples
  // the value its source held before this edge regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end
  end

  // Raw decode of the pixel the counters hold this cycle.
  assign vis0  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs0_n = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs0_n = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  assign col0  = vis0 ? 6'(h_cnt >> TILE_SHIFT) : OFF_GRID;
  assign row0  = vis0 ? 6'(v_cnt >> TILE_SHIFT) : OFF_GRID;

  // Stage 1 publishes the tile coordinate; stage 2 lines up with the draw flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_col         <= OFF_GRID;
      o_row         <= OFF_GRID;
      o_frame_start <= 1'b0;
      vis1          <= 1'b0;
      hs1_n         <= 1'b1;
      vs1_n         <= 1'b1;
      vis2          <= 1'b0;
      hs2_n         <= 1'b1;
      vs2_n         <= 1'b1;
    end else begin
      o_col         <= col0;
      o_row         <= row0;
      o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
      vis1          <= vis0;
      hs1_n         <= hs0_n;
      vs1_n         <= vs0_n;
      vis2          <= vis1;
      hs2_n         <= hs1_n;
      vs2_n         <= vs1_n;
    end
  end

  always_comb begin
    // NOTE: the default assignment up front covers every path, so no latch is inferred.
    pix_rgb = RGB_BLACK;
    if (vis2) begin
      if (i_draw_ball)    pix_rgb = RGB_BALL;
      else if (i_draw_p1) pix_rgb = RGB_P1;
      else if (i_draw_p2) pix_rgb = RGB_P2;
    end
  end

  // Colour and syncs leave through the same register stage so they stay aligned.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rgb_q   <= RGB_BLACK;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
    end else begin
      rgb_q   <= pix_rgb;
      o_hsync <= hs2_n;
      o_vsync <= vs2_n;
    end
  end

  assign o_red = rgb_q.red;
  assign o_grn = rgb_q.grn;
  assign o_blu = rgb_q.blu;

endmodule

// File: tb/tb_game_grid_scan.sv
// Scoreboard bench for game_grid_scan: full horizontal timing with a shortened
// vertical field so two frames and a mid-frame reset fit in a short run.
module tb_game_grid_scan;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 32, VF = 2, VS = 2, VB = 1;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_draw_ball, i_draw_p1, i_draw_p2;
  logic [5:0] o_col, o_row;
  logic       o_frame_start, o_hsync, o_vsync;
  logic [2:0] o_red, o_grn, o_blu;

  always #20 i_clk = ~i_clk;

  game_grid_scan #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TILE_SHIFT(4)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_draw_ball  (i_draw_ball),
    .i_draw_p1    (i_draw_p1),
    .i_draw_p2    (i_draw_p2),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_frame_start(o_frame_start),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_red        (o_red),
    .o_grn        (o_grn),
    .o_blu        (o_blu)
  );

  typedef struct { bit ok; int h; int v; } pix_t;
  typedef struct { logic [5:0] col; logic [5:0] row; logic fs; } pos_exp_t;
  typedef struct { pix_t pix; logic [8:0] rgb; logic hs; logic vs; } out_exp_t;

  pos_exp_t pos_q[$];
  out_exp_t out_q[$];

  // cur: pixel in the counters; d1: pixel on o_col/o_row; d2: pixel whose draws are driven.
  pix_t cur, d1, d2;
  bit   rst_prev;
  int   checks = 0, errors = 0, cyc = 0;
  int   line_start = -1, frame_out_start = -1, hs_fall = -1, vs_fall = -1, last_fs = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  bit   arm_mid = 1'b0, mid_done = 1'b0, fs_spacing_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic pix_t next_pix(pix_t p);
    pix_t n;
    n = p;
    n.h = p.h + 1;
    if (n.h == HT) begin
      n.h = 0;
      n.v = (p.v + 1 == VT) ? 0 : p.v + 1;
    end
    return n;
  endfunction

  // Draw stimulus {ball,p1,p2} for the pixel whose flags are due this cycle.
  function automatic logic [2:0] pattern(pix_t p);
    if (!p.ok || p.v >= 24) return 3'b111;
    if (p.v == 16 && p.h == 80) return 3'b100;
    if (p.v == 0) begin
      case (p.h / 16)
        0:  return 3'b100;
        10: return 3'b111;
        20: return 3'b011;
        21: return 3'b001;
        22: return 3'b010;
        23: return 3'b101;
        39: return 3'b110;
        40: return 3'b111;
        default: return 3'b000;
      endcase
    end
    return 3'b000;
  endfunction

  function automatic logic [8:0] expect_rgb(pix_t p, logic [2:0] d);
    if (!p.ok || p.h >= HV || p.v >= VV) return 9'o000;
    if (d[2]) return 9'o777;
    if (d[1]) return 9'o070;
    if (d[0]) return 9'o077;
    return 9'o000;
  endfunction

  function automatic pos_exp_t pos_from(pix_t p);
    pos_exp_t e;
    bit vis;
    vis   = (p.h < HV) && (p.v < VV);
    e.col = vis ? 6'(p.h / 16) : 6'd63;
    e.row = vis ? 6'(p.v / 16) : 6'd63;
    e.fs  = (p.h == 0) && (p.v == 0);
    return e;
  endfunction

  task automatic push_reset_exp();
    pos_q.push_back('{col: 6'd63, row: 6'd63, fs: 1'b0});
    out_q.push_back('{pix: '{ok: 1'b0, h: 0, v: 0}, rgb: 9'd0, hs: 1'b1, vs: 1'b1});
  endtask

  task automatic measure(input pix_t op);
    if (op.ok && op.h == 0) begin
      line_start = cyc;
      if (op.v == 0) frame_out_start = cyc;
    end
    if (prev_hs === 1'b1 && o_hsync === 1'b0) begin
      if (line_start >= 0) check("hsync_start_offset", cyc - line_start, HV + HF);
      hs_fall = cyc;
    end
    if (prev_hs === 1'b0 && o_hsync === 1'b1 && hs_fall >= 0)
      check("hsync_width", cyc - hs_fall, HS);
    if (prev_vs === 1'b1 && o_vsync === 1'b0) begin
      if (frame_out_start >= 0) check("vsync_start_offset", cyc - frame_out_start, (VV + VF) * HT);
      vs_fall = cyc;
    end
    if (prev_vs === 1'b0 && o_vsync === 1'b1 && vs_fall >= 0)
      check("vsync_width", cyc - vs_fall, VS * HT);
    if (o_frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        check("frame_start_spacing", cyc - last_fs, FRAME);
        fs_spacing_done = 1'b1;
      end
      last_fs = cyc;
    end
    prev_hs = o_hsync;
    prev_vs = o_vsync;
  endtask

  // One clock: advance the model, compare against last cycle's expectations,
  // then drive this cycle's inputs and queue what they should produce.
  task automatic tick(input bit rst_req);
    pos_exp_t   pe;
    out_exp_t   oe;
    logic [2:0] dr;
    bit         mid_hit, rst_now;
    @(posedge i_clk);
    #1;
    cyc++;
    if (rst_prev) begin
      cur = '{ok: 1'b1, h: 0, v: 0};
      d1  = '{ok: 1'b0, h: 0, v: 0};
      d2  = '{ok: 1'b0, h: 0, v: 0};
    end else begin
      d2  = d1;
      d1  = cur;
      cur = next_pix(cur);
    end
    pe = pos_q.pop_front();
    oe = out_q.pop_front();
    check("col", 32'(o_col), 32'(pe.col));
    check("row", 32'(o_row), 32'(pe.row));
    check("frame_start", 32'(o_frame_start), 32'(pe.fs));
    check("rgb", 32'({o_red, o_grn, o_blu}), 32'(oe.rgb));
    check("hsync", 32'(o_hsync), 32'(oe.hs));
    check("vsync", 32'(o_vsync), 32'(oe.vs));
    measure(oe.pix);

    mid_hit = arm_mid && cur.h == 700 && cur.v == VV + VF + 1;
    if (mid_hit) begin
      arm_mid  = 1'b0;
      mid_done = 1'b1;
    end
    rst_now = rst_req || mid_hit;
    dr = pattern(d2);
    i_reset = rst_now;
    {i_draw_ball, i_draw_p1, i_draw_p2} = dr;

    if (rst_now) begin
      push_reset_exp();
      line_start = -1; frame_out_start = -1;
      hs_fall = -1; vs_fall = -1; last_fs = -1;
    end else begin
      pos_q.push_back(pos_from(cur));
      oe.pix = d2;
      oe.rgb = expect_rgb(d2, dr);
      oe.hs  = !(d2.ok && d2.h >= HV + HF && d2.h <= HV + HF + HS - 1);
      oe.vs  = !(d2.ok && d2.v >= VV + VF && d2.v <= VV + VF + VS - 1);
      out_q.push_back(oe);
    end
    rst_prev = rst_now;
  endtask

  initial begin
    i_reset = 1'b1;
    {i_draw_ball, i_draw_p1, i_draw_p2} = 3'b111;
    cur = '{ok: 1'b0, h: 0, v: 0};
    d1 = cur;
    d2 = cur;
    push_reset_exp();
    rst_prev = 1'b1;

    // Power-up reset held for three edges, then released.
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    check("rst_col", 32'(o_col), 32'd63);
    check("rst_row", 32'(o_row), 32'd63);
    check("rst_hsync", 32'(o_hsync), 32'd1);
    check("rst_vsync", 32'(o_vsync), 32'd1);
    check("rst_rgb", 32'({o_red, o_grn, o_blu}), 32'd0);
    check("rst_frame_start", 32'(o_frame_start), 32'd0);

    tick(1'b0);
    check("release_frame_start", 32'(o_frame_start), 32'd1);
    check("release_col", 32'(o_col), 32'd0);
    check("release_row", 32'(o_row), 32'd0);

    // Free-run the first frame up to (700, second vsync line), then pulse reset there.
    arm_mid = 1'b1;
    for (int i = 0; i < FRAME + 10 && !mid_done; i++) tick(1'b0);
    check("mid_reset_reached", 32'(mid_done), 32'd1);
    check("pre_reset_hsync_low", 32'(o_hsync), 32'd0);
    check("pre_reset_vsync_low", 32'(o_vsync), 32'd0);

    tick(1'b0);
    check("mid_rst_hsync", 32'(o_hsync), 32'd1);
    check("mid_rst_vsync", 32'(o_vsync), 32'd1);
    check("mid_rst_rgb", 32'({o_red, o_grn, o_blu}), 32'd0);
    check("mid_rst_col", 32'(o_col), 32'd63);

    tick(1'b0);
    check("restart_frame_start", 32'(o_frame_start), 32'd1);
    check("restart_col", 32'(o_col), 32'd0);

    // Run the restarted frame through to the next frame start.
    for (int i = 0; i < FRAME + 10 && !fs_spacing_done; i++) tick(1'b0);
    check("frame_spacing_seen", 32'(fs_spacing_done), 32'd1);
    repeat (20) tick(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
